// File: rtl/state_fill_ctrl_if.sv
// rtl/state_fill_ctrl_if.sv - channel state RAM read port between fill sequencer and RAM arbiter
interface state_fill_ctrl_if #(
  parameter int CH_WIDTH = 5
);
  logic                  ram_req;
  logic                  ram_gnt;
  logic [CH_WIDTH+4:0]   ram_addr;
  logic [31:0]           ram_rdata;

  modport master (
    output ram_req,
    output ram_addr,
    input  ram_gnt,
    input  ram_rdata
  );

  modport slave (
    input  ram_req,
    input  ram_addr,
    output ram_gnt,
    output ram_rdata
  );
endinterface

// File: rtl/state_fill_ctrl.sv
// rtl/state_fill_ctrl.sv - channel state fill sequencer; optional stall timeout under STATE_FILL_TIMEOUT_EN
module state_fill_ctrl #(
  parameter int CH_WIDTH    = 5,
  parameter int NUM_WORDS   = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fill_start,
  input  logic [CH_WIDTH-1:0] channel_index,
  input  logic                fill_abort,
  state_fill_ctrl_if.master   bus,
  output logic                fill_busy,
  output logic                fill_enable,
  output logic                state_rd,
  output logic [4:0]          state_addr,
  output logic [31:0]         state_d4rd,
  output logic                fill_done
`ifdef STATE_FILL_TIMEOUT_EN
  ,
  output logic                fill_error
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_OFF = 5'(NUM_WORDS - 1);

  state_t                state;
  logic [CH_WIDTH-1:0]   channel;
  logic [4:0]            offset;
  logic [RAM_LATENCY-1:0] pipe_v;
  logic [4:0]            pipe_off [RAM_LATENCY];
  logic                  grant;
  logic                  upstream_busy;
  logic                  kill;

  assign grant = (state == READ) && bus.ram_req && bus.ram_gnt;

  // The last pipeline stage is the state_rd strobe itself, so a read granted in
  // cycle T strobes in T+RAM_LATENCY; only the earlier stages hold back DRAIN.
  assign state_rd   = pipe_v[RAM_LATENCY-1];
  assign state_addr = pipe_off[RAM_LATENCY-1];

  always_comb begin
    upstream_busy = 1'b0;
    for (int i = 0; i < RAM_LATENCY - 1; i++) begin
      upstream_busy = upstream_busy | pipe_v[i];
    end
  end

`ifdef STATE_FILL_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic       timeout;

  assign timeout = (state == READ) && bus.ram_req && !bus.ram_gnt && (stall_cnt == 8'd254);
  assign kill    = ((state != IDLE) && fill_abort) || timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= 8'd0;
      fill_error <= 1'b0;
    end else begin
      fill_error <= timeout;
      if (state != READ || bus.ram_gnt || timeout) begin
        stall_cnt <= 8'd0;
      end else if (bus.ram_req) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end
  end
`else
  assign kill = (state != IDLE) && fill_abort;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      channel      <= '0;
      offset       <= 5'd0;
      pipe_v       <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_off[i] <= 5'd0;
      end
      bus.ram_req  <= 1'b0;
      bus.ram_addr <= '0;
      fill_busy    <= 1'b0;
      fill_enable  <= 1'b0;
      fill_done    <= 1'b0;
      state_d4rd   <= 32'd0;
    end else begin
      pipe_v[0]   <= grant;
      pipe_off[0] <= offset;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_off[i] <= pipe_off[i-1];
      end
      // Data of a strobed word is kept even when the fill is aborted that cycle.
      if (state_rd) begin
        state_d4rd <= bus.ram_rdata;
      end
      fill_done <= 1'b0;

      if (kill) begin
        state       <= IDLE;
        pipe_v      <= '0;
        offset      <= 5'd0;
        bus.ram_req <= 1'b0;
        fill_busy   <= 1'b0;
        fill_enable <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fill_start) begin
              channel      <= channel_index;
              offset       <= 5'd0;
              bus.ram_addr <= {channel_index, 5'd0};
              bus.ram_req  <= 1'b1;
              fill_busy    <= 1'b1;
              fill_enable  <= 1'b1;
              state        <= READ;
            end
          end
          READ: begin
            if (grant) begin
              if (offset == LAST_OFF) begin
                bus.ram_req <= 1'b0;
                state       <= DRAIN;
              end else begin
                offset       <= offset + 5'd1;
                bus.ram_addr <= {channel, offset + 5'd1};
              end
            end
          end
          DRAIN: begin
            if (!upstream_busy) begin
              fill_done <= 1'b1;
              state     <= DONE;
            end
          end
          DONE: begin
            fill_busy   <= 1'b0;
            fill_enable <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
